// File: rtl/parameter_tx_framer.sv
// ---------------------------------------------------------------------------
// parameter_tx_framer
// Reads word_count 32-bit words from the second port of the parameter TX RAM
// and sends them as a framed byte stream to the serial link PHY:
//     SOF, LEN_H, LEN_L, payload (each word MSB byte first), CHK
//
// Ports
//   clk, reset       single clock, synchronous active-high reset
//   start            one-cycle request, sampled only in IDLE
//   base_addr        first RAM word address (wraps modulo 2**ADDR_W)
//   word_count       payload words; values above MAX_WORDS saturate
//   busy / done      busy for the whole frame; done pulses one cycle after CHK
//   ram_address      RAM port-2 address (the RAM registers it)
//   ram_chipselect   RAM port-2 chipselect
//   ram_readdata     RAM port-2 q, valid one cycle after ram_address
//   tx_data/tx_valid/tx_ready   valid/ready byte stream
// ---------------------------------------------------------------------------
module parameter_tx_framer #(
    parameter int          ADDR_W    = 11,
    parameter int          MAX_WORDS = 1024,
    parameter logic [7:0]  SOF_BYTE  = 8'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [10:0]       word_count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_chipselect,
    input  logic [31:0]       ram_readdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready
);

    localparam logic [10:0] MAX_CNT = 11'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE, ST_SOF, ST_LENH, ST_LENL, ST_PAY, ST_CHK, ST_DONE
    } state_t;

    state_t            state_reg,  state_next;
    logic [ADDR_W-1:0] addr_reg,   addr_next;
    logic              cs_reg,     cs_next;
    logic [10:0]       count_reg,  count_next;
    logic [10:0]       rem_reg,    rem_next;    // words still to be loaded
    logic [31:0]       shift_reg,  shift_next;  // current word, bytes not yet presented
    logic [1:0]        idx_reg,    idx_next;    // byte index inside current word
    logic [7:0]        sum_reg,    sum_next;    // running sum of covered bytes already sent
    logic [7:0]        data_reg,   data_next;

    logic [10:0] sat_count;
    logic        beat;
    logic        do_load;
    logic [7:0]  sum_beat;

    assign sat_count = (word_count > MAX_CNT) ? MAX_CNT : word_count;
    assign beat      = tx_valid & tx_ready;
    assign sum_beat  = sum_reg + data_reg;

    assign tx_valid       = (state_reg == ST_SOF)  || (state_reg == ST_LENH) ||
                            (state_reg == ST_LENL) || (state_reg == ST_PAY)  ||
                            (state_reg == ST_CHK);
    assign busy           = tx_valid;
    assign done           = (state_reg == ST_DONE);
    assign tx_data        = data_reg;
    assign ram_address    = addr_reg;
    assign ram_chipselect = cs_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            addr_reg  <= '0;
            cs_reg    <= 1'b0;
            count_reg <= '0;
            rem_reg   <= '0;
            shift_reg <= '0;
            idx_reg   <= '0;
            sum_reg   <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            addr_reg  <= addr_next;
            cs_reg    <= cs_next;
            count_reg <= count_next;
            rem_reg   <= rem_next;
            shift_reg <= shift_next;
            idx_reg   <= idx_next;
            sum_reg   <= sum_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        addr_next  = addr_reg;
        cs_next    = cs_reg;
        count_next = count_reg;
        rem_next   = rem_reg;
        shift_next = shift_reg;
        idx_next   = idx_reg;
        sum_next   = sum_reg;
        data_next  = data_reg;
        do_load    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_SOF;
                    addr_next  = base_addr;
                    // An empty frame never touches the RAM.
                    cs_next    = (sat_count != 11'd0);
                    count_next = sat_count;
                    rem_next   = sat_count;
                    sum_next   = 8'd0;
                    data_next  = SOF_BYTE;
                end
            end
            ST_SOF: begin
                if (beat) begin
                    state_next = ST_LENH;
                    data_next  = {5'b0, count_reg[10:8]};
                end
            end
            ST_LENH: begin
                if (beat) begin
                    state_next = ST_LENL;
                    data_next  = count_reg[7:0];
                    sum_next   = sum_beat;
                end
            end
            ST_LENL: begin
                if (beat) begin
                    sum_next = sum_beat;
                    if (rem_reg == 11'd0) begin
                        state_next = ST_CHK;
                        data_next  = 8'd0 - sum_beat;
                    end else begin
                        do_load = 1'b1;
                    end
                end
            end
            ST_PAY: begin
                if (beat) begin
                    sum_next = sum_beat;
                    if (idx_reg == 2'd3) begin
                        if (rem_reg == 11'd0) begin
                            state_next = ST_CHK;
                            data_next  = 8'd0 - sum_beat;
                        end else begin
                            do_load = 1'b1;
                        end
                    end else begin
                        shift_next = {shift_reg[23:0], 8'h00};
                        data_next  = shift_reg[23:16];
                        idx_next   = idx_reg + 2'd1;
                    end
                end
            end
            ST_CHK: begin
                if (beat) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase

        // The address has been stable for at least one cycle before any load,
        // so ram_readdata already holds the word at addr_reg.
        if (do_load) begin
            state_next = ST_PAY;
            shift_next = ram_readdata;
            data_next  = ram_readdata[31:24];
            idx_next   = 2'd0;
            rem_next   = rem_reg - 11'd1;
            if (rem_reg == 11'd1) cs_next   = 1'b0;
            else                  addr_next = addr_reg + 1'b1;
        end
    end

endmodule

// File: tb/tb_parameter_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_parameter_tx_framer
// Scoreboard bench: each frame's expected bytes are queued when start is
// driven; a negedge monitor pops and compares every accepted byte, checks
// stall stability and the done pulse position.
// ---------------------------------------------------------------------------
module tb_parameter_tx_framer;

    localparam int ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [10:0]       word_count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_address;
    logic              ram_chipselect;
    logic [31:0]       ram_readdata;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;

    parameter_tx_framer #(.ADDR_W(ADDR_W), .MAX_WORDS(1024), .SOF_BYTE(8'hA5)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .word_count     (word_count),
        .busy           (busy),
        .done           (done),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_readdata   (ram_readdata),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready)
    );

    always #5 clk = ~clk;

    // RAM port 2 model: registered address, data one cycle later.
    logic [31:0] mem [0:2047];
    always @(posedge clk) begin
        if (ram_chipselect) ram_readdata <= mem[ram_address];
    end

    int        n_cmp = 0;
    int        n_err = 0;
    logic [7:0] exp_q [$];
    int        beat_cnt = 0;
    bit        expect_done = 0;
    bit        no_cs = 0;
    bit        prev_stall = 0;
    logic [7:0] prev_data = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Monitor: inputs change just after posedge, so negedge values are the
    // ones the DUT sees at the next edge.
    always @(negedge clk) begin
        if (!reset) begin
            if (expect_done || done) begin
                check_val("done_pulse", {29'b0, done, busy, tx_valid}, {29'b0, expect_done, 2'b00});
                expect_done = 0;
            end
            if (prev_stall) begin
                check_val("stall_valid", {31'b0, tx_valid}, 32'd1);
                check_val("stall_data", {24'b0, tx_data}, {24'b0, prev_data});
            end
            if (no_cs && ram_chipselect) check_val("cs_zero_frame", 32'd1, 32'd0);
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("extra_beat", {24'b0, tx_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check_val("beat", {24'b0, tx_data}, {24'b0, e});
                    if (exp_q.size() == 0) expect_done = 1;
                end
                beat_cnt++;
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 0;
        end
    end

    // Drives one frame. rmode=1 randomises tx_ready and sprinkles start
    // pulses while busy. abort_at>=0 asserts reset while that beat index
    // (counted from SOF) is presented.
    task automatic run_frame(input logic [10:0] base, input logic [10:0] cnt,
                             input bit rmode, input int abort_at);
        logic [10:0] sat;
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [31:0] w;
        int          beats0;
        int          cyc;
        bit          fin;
        sat = (cnt > 11'd1024) ? 11'd1024 : cnt;
        sum = 8'h00;
        exp_q.push_back(8'hA5);
        b = {5'b0, sat[10:8]}; exp_q.push_back(b); sum += b;
        b = sat[7:0];          exp_q.push_back(b); sum += b;
        for (int i = 0; i < int'(sat); i++) begin
            w = mem[11'(int'(base) + i)];
            for (int k = 3; k >= 0; k--) begin
                b = w[8*k +: 8];
                exp_q.push_back(b);
                sum += b;
            end
        end
        exp_q.push_back(8'h00 - sum);
        no_cs = (sat == 11'd0);
        beats0 = beat_cnt;

        @(posedge clk); #1;
        start = 1; base_addr = base; word_count = cnt; tx_ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
        start = 0; base_addr = ~base; word_count = 11'd5;
        check_val("start_busy", {31'b0, busy}, 32'd1);
        check_val("start_sof", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'hA5});
        check_val("start_addr", {21'b0, ram_address}, {21'b0, base});
        check_val("start_cs", {31'b0, ram_chipselect}, {31'b0, sat != 11'd0});
        cyc = 1;
        fin = 0;
        while (!fin && cyc < 20000) begin
            if (abort_at >= 0 && (beat_cnt - beats0) == abort_at) begin
                tx_ready = 1;
                reset = 1;
                @(posedge clk); #1;
                reset = 0;
                check_val("abort_idle", {28'b0, tx_valid, busy, done, ram_chipselect}, 32'd0);
                exp_q.delete();
                expect_done = 0;
                repeat (3) @(posedge clk);
                #1;
                check_val("abort_no_done", {30'b0, done, busy}, 32'd0);
                fin = 1;
            end else begin
                if (rmode) begin
                    tx_ready = 1'($urandom_range(0, 1));
                    start    = busy & 1'($urandom_range(0, 1));
                end
                @(posedge clk); #1;
                cyc++;
                if (done) begin
                    fin = 1;
                    start = 0;
                    if (!rmode) check_val("frame_cycles", cyc, 5 + 4 * int'(sat));
                    check_val("frame_beats", beat_cnt - beats0, 4 + 4 * int'(sat));
                end
            end
        end
        if (!fin) check_val("timeout", 32'd1, 32'd0);
        start = 0;
        tx_ready = 1;
        @(posedge clk); #1;
        check_val("idle_after", {30'b0, busy, tx_valid}, 32'd0);
        no_cs = 0;
        $display("frame base=%h count=%0d ready_mode=%0d abort=%0d checks=%0d errors=%0d",
                 base, cnt, rmode, abort_at, n_cmp, n_err);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        mem[11'h010] = 32'h11223344;
        mem[11'h7FF] = 32'hDEADBEEF;
        mem[11'h000] = 32'h01020304;

        reset = 1; start = 0; base_addr = '0; word_count = '0; tx_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_state", {24'b0, busy, done, tx_valid, ram_chipselect, 4'b0}, 32'd0);
        check_val("reset_data", {24'b0, tx_data}, 32'd0);
        check_val("reset_addr", {21'b0, ram_address}, 32'd0);
        reset = 0;

        run_frame(11'h010, 11'd1,    1'b0, -1);
        run_frame(11'h010, 11'd1,    1'b1, -1);
        run_frame(11'h7FF, 11'd2,    1'b0, -1);
        run_frame(11'h7FF, 11'd2,    1'b1, -1);
        run_frame(11'h123, 11'd0,    1'b0, -1);
        run_frame(11'h200, 11'd2000, 1'b0, -1);
        run_frame(11'h100, 11'd8,    1'b0, 25);
        run_frame(11'h100, 11'd8,    1'b0, -1);
        run_frame(11'h3F0, 11'd6,    1'b1, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
